// File: rtl/spi_ctrl_pkg.sv
// Shared types and frame constants for the SPI master/arbiter slice.
package spi_ctrl_pkg;

  localparam int   ADDR_W     = 7;
  localparam int   DATA_W     = 16;
  localparam int   FRAME_BITS = ADDR_W + 1 + DATA_W;  // {addr, rwb, data}
  localparam logic RWB_READ   = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_e;

  // Index width that stays legal (>=1 bit) even for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr_i wins.
module spi_rr_arbiter
  import spi_ctrl_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             gnt_valid_o,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o
);

  // Scan requesters starting at the pointer, wrapping modulo N_REQ.
  always_comb begin
    logic [IDX_W-1:0] idx;
    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    gnt_valid_o = 1'b0;
    gnt_o       = '0;
    gnt_idx_o   = '0;
    idx         = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = IDX_W'((int'(ptr_i) + k) % N_REQ);
      if (!gnt_valid_o && req_i[idx]) begin
        gnt_valid_o = 1'b1;
        gnt_o[idx]  = 1'b1;
        gnt_idx_o   = idx;
      end
    end
  end

endmodule

// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter plus SPI frame sequencer sharing one SPI slave among N_REQ requesters.
module spi_master_arbiter
  import spi_ctrl_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int CLK_DIV = 2,
  parameter int GAP_CYC = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0]        req_rwb,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_wdata,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic                    busy,
  output logic                    csz,
  output logic                    sclk,
  output logic                    sdi,
  input  logic                    sdo
);

  localparam int                IDX_W          = idx_width(N_REQ);
  localparam int                CNT_MAX        = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
  localparam int                CNT_W          = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]  DIV_LAST       = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST       = CNT_W'(GAP_CYC - 1);
  localparam logic [4:0]        FIRST_DATA_BIT = 5'(ADDR_W + 1);
  localparam logic [4:0]        LAST_BIT       = 5'(FRAME_BITS - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST       = IDX_W'(N_REQ - 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        div_q, div_d;
  logic [4:0]              bit_q, bit_d;
  logic [FRAME_BITS-1:0]   tx_q, tx_d;
  logic [DATA_W-1:0]       rx_q, rx_d;
  logic                    is_read_q, is_read_d;
  logic [IDX_W-1:0]        gidx_q, gidx_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic                    csz_q, csz_d;
  logic                    sclk_q, sclk_d;
  logic                    sdi_q, sdi_d;
  logic                    busy_q, busy_d;
  logic [N_REQ-1:0]        req_ready_q, req_ready_d;
  logic [N_REQ-1:0]        rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]       rsp_rdata_q, rsp_rdata_d;

  logic                    gnt_valid;
  logic [N_REQ-1:0]        gnt;
  logic [IDX_W-1:0]        gnt_idx;
  logic                    gnt_is_read;
  logic [FRAME_BITS-1:0]   tx_load;

  spi_rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req_i       (req_valid),
    .ptr_i       (ptr_q),
    .gnt_valid_o (gnt_valid),
    .gnt_o       (gnt),
    .gnt_idx_o   (gnt_idx)
  );

  // Frame image for the granted requester; read frames carry zero data so sdi idles low.
  assign gnt_is_read = (req_rwb[gnt_idx] == RWB_READ);
  assign tx_load     = {req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W],
                        req_rwb[gnt_idx],
                        gnt_is_read ? {DATA_W{1'b0}} : req_wdata[int'(gnt_idx)*DATA_W +: DATA_W]};

  // Next-state and registered-output logic for the frame sequencer.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_d       = bit_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    is_read_d   = is_read_q;
    gidx_d      = gidx_q;
    ptr_d       = ptr_q;
    csz_d       = csz_q;
    sclk_d      = sclk_q;
    sdi_d       = sdi_q;
    busy_d      = busy_q;
    req_ready_d = '0;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          state_d     = SETUP;
          div_d       = '0;
          bit_d       = '0;
          req_ready_d = gnt;
          gidx_d      = gnt_idx;
          ptr_d       = (gnt_idx == IDX_LAST) ? '0 : gnt_idx + 1'b1;
          is_read_d   = gnt_is_read;
          tx_d        = tx_load;
          rx_d        = '0;
          csz_d       = 1'b0;
          sclk_d      = 1'b0;
          sdi_d       = tx_load[FRAME_BITS-1];
          busy_d      = 1'b1;
        end
      end

      SETUP: begin
        div_d = div_q + 1'b1;
        if (div_q == DIV_LAST) begin
          state_d = SHIFT;
          div_d   = '0;
        end
      end

      SHIFT: begin
        div_d = div_q + 1'b1;
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            // Falling edge: sample read data, then present the next bit while sclk is low.
            sclk_d = 1'b0;
            if (is_read_q && (bit_q >= FIRST_DATA_BIT)) begin
              rx_d = {rx_q[DATA_W-2:0], sdo};
            end
            if (bit_q == LAST_BIT) begin
              state_d = HOLD;
              sdi_d   = 1'b0;
            end else begin
              bit_d = bit_q + 1'b1;
              tx_d  = tx_q << 1;
              sdi_d = tx_q[FRAME_BITS-2];
            end
          end
        end
      end

      HOLD: begin
        div_d = div_q + 1'b1;
        if (div_q == DIV_LAST) begin
          state_d             = GAP;
          div_d               = '0;
          csz_d               = 1'b1;
          rsp_valid_d[gidx_q] = 1'b1;
          rsp_rdata_d         = is_read_q ? rx_q : '0;
        end
      end

      GAP: begin
        div_d = div_q + 1'b1;
        if (div_q == GAP_LAST) begin
          state_d = IDLE;
          div_d   = '0;
          busy_d  = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any in-flight frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q     <= IDLE;
      div_q       <= '0;
      bit_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      is_read_q   <= 1'b0;
      gidx_q      <= '0;
      ptr_q       <= '0;
      csz_q       <= 1'b1;
      sclk_q      <= 1'b0;
      sdi_q       <= 1'b0;
      busy_q      <= 1'b0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      is_read_q   <= is_read_d;
      gidx_q      <= gidx_d;
      ptr_q       <= ptr_d;
      csz_q       <= csz_d;
      sclk_q      <= sclk_d;
      sdi_q       <= sdi_d;
      busy_q      <= busy_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign busy      = busy_q;
  assign csz       = csz_q;
  assign sclk      = sclk_q;
  assign sdi       = sdi_q;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed bench for spi_master_arbiter with a behavioural SPI memory slave.
module tb_spi_master_arbiter;

  localparam int N_REQ   = 2;
  localparam int CLK_DIV = 2;
  localparam int GAP_CYC = 4;
  localparam int FRAME_LAT = CLK_DIV * 50;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_rwb;
  logic [13:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [15:0] rsp_rdata;
  logic        busy, csz, sclk, sdi, sdo;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [15:0] sb_mem [128];

  spi_master_arbiter #(
    .N_REQ   (N_REQ),
    .CLK_DIV (CLK_DIV),
    .GAP_CYC (GAP_CYC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_rwb   (req_rwb),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .busy      (busy),
    .csz       (csz),
    .sclk      (sclk),
    .sdi       (sdi),
    .sdo       (sdo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Behavioural slave: 7 addr bits, rwb, 16 data bits; sdo shifts out on sclk falling edges.
  logic [15:0] sl_mem [128];
  logic [23:0] sl_shift = '0;
  logic [23:0] last_frame = '0;
  logic [15:0] sl_out = '0;
  int          sl_bits = 0;
  bit          sl_init = 1'b0;

  always @(posedge sclk or negedge sclk or posedge csz) begin
    if (csz !== 1'b0) begin
      if (!sl_init) begin
        for (int a = 0; a < 128; a++) sl_mem[a] = '0;
        sl_init = 1'b1;
      end
      sl_bits = 0;
      sl_out  = '0;
      sdo     = 1'b0;
    end else if (sclk === 1'b1) begin
      sl_shift = {sl_shift[22:0], sdi};
      sl_bits++;
      if (sl_bits == 24) begin
        last_frame = sl_shift;
        if (sl_shift[16] == 1'b0) sl_mem[sl_shift[23:17]] = sl_shift[15:0];
      end
    end else begin
      if (sl_bits == 8 && sl_shift[0]) sl_out = sl_mem[sl_shift[7:1]];
      else if (sl_bits == 8)           sl_out = 16'hFFFF;
      else                             sl_out = {sl_out[14:0], 1'b1};
      sdo = sl_out[15];
    end
  end

  // Line monitors: sdi must not move while sclk is high; track the shortest csz-high gap.
  int   sdi_viol = 0;
  logic sdi_prev = 1'b0;
  int   hi_run   = 0;
  int   min_gap  = 1000;
  bit   seen_lo  = 1'b0;

  always @(negedge clk) begin
    if (sclk === 1'b1 && csz === 1'b0 && reset === 1'b0 && sdi !== sdi_prev) sdi_viol++;
    sdi_prev = sdi;
    if (csz === 1'b1) begin
      hi_run++;
    end else if (csz === 1'b0) begin
      if (seen_lo && hi_run > 0 && hi_run < min_gap) min_gap = hi_run;
      hi_run  = 0;
      seen_lo = 1'b1;
    end
  end

  // Drive one request, wait for its accept and completion (bounded); latency measured ready->rsp.
  task automatic issue(input int idx, input bit rwb, input logic [6:0] addr, input logic [15:0] wdata,
                       output bit ok, output int lat, output logic [15:0] rdata);
    int t0;
    ok = 1'b0; lat = 0; rdata = 'x; t0 = 0;
    req_rwb[idx]          = rwb;
    req_addr[idx*7 +: 7]  = addr;
    req_wdata[idx*16 +: 16] = wdata;
    req_valid[idx]        = 1'b1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (req_ready[idx]) begin ok = 1'b1; t0 = cyc; break; end
    end
    req_valid[idx] = 1'b0;
    if (ok) begin
      ok = 1'b0;
      for (int n = 0; n < 400; n++) begin
        @(negedge clk);
        if (rsp_valid[idx]) begin ok = 1'b1; lat = cyc - t0; rdata = rsp_rdata; break; end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = '0; req_rwb = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    total++; if (csz !== 1'b1)        begin bad++; $display("FAIL reset_csz got=%b want=1", csz); end
    total++; if (sclk !== 1'b0)       begin bad++; $display("FAIL reset_sclk got=%b want=0", sclk); end
    total++; if (sdi !== 1'b0)        begin bad++; $display("FAIL reset_sdi got=%b want=0", sdi); end
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_req_ready got=%b want=00", req_ready); end
    total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL reset_rsp_valid got=%b want=00", rsp_valid); end
    total++; if (rsp_rdata !== 16'h0) begin bad++; $display("FAIL reset_rsp_rdata got=%h want=0000", rsp_rdata); end
    reset = 1'b0;
    repeat (5) @(negedge clk);
    total++; if (busy !== 1'b0 || csz !== 1'b1) begin bad++; $display("FAIL idle_no_req busy=%b csz=%b want 0/1", busy, csz); end
  endtask

  task automatic test_write();
    bit ok; int lat; logic [15:0] rd;
    issue(0, 1'b0, 7'h15, 16'hA5C3, ok, lat, rd);
    sb_mem[7'h15] = 16'hA5C3;
    total++; if (!ok)            begin bad++; $display("FAIL write_timeout got=0 want=1"); end
    total++; if (lat !== FRAME_LAT) begin bad++; $display("FAIL write_latency got=%0d want=%0d", lat, FRAME_LAT); end
    total++; if (last_frame !== 24'b0010101_0_1010010111000011)
      begin bad++; $display("FAIL write_frame got=%b want=%b", last_frame, 24'b0010101_0_1010010111000011); end
    total++; if (rd !== 16'h0)   begin bad++; $display("FAIL write_rdata got=%h want=0000", rd); end
    total++; if (busy !== 1'b1 || csz !== 1'b1) begin bad++; $display("FAIL write_gap busy=%b csz=%b want 1/1", busy, csz); end
    repeat (5) @(negedge clk);
    total++; if (busy !== 1'b0)  begin bad++; $display("FAIL write_busy_drop got=%b want=0", busy); end
  endtask

  task automatic test_read();
    bit ok; int lat; logic [15:0] rd;
    issue(1, 1'b1, 7'h15, 16'hBEEF, ok, lat, rd);
    total++; if (!ok)               begin bad++; $display("FAIL read_timeout got=0 want=1"); end
    total++; if (lat !== FRAME_LAT) begin bad++; $display("FAIL read_latency got=%0d want=%0d", lat, FRAME_LAT); end
    total++; if (rd !== 16'hA5C3)   begin bad++; $display("FAIL read_rdata got=%h want=a5c3", rd); end
    total++; if (last_frame[23:16] !== 8'b0010101_1) begin bad++; $display("FAIL read_hdr got=%b want=00101011", last_frame[23:16]); end
    total++; if (last_frame[15:0] !== 16'h0) begin bad++; $display("FAIL read_sdi_low got=%h want=0000", last_frame[15:0]); end
    @(negedge clk);
    total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL read_rsp_pulse got=%b want=00", rsp_valid); end
    repeat (10) @(negedge clk);
    total++; if (rsp_rdata !== 16'hA5C3) begin bad++; $display("FAIL read_rdata_hold got=%h want=a5c3", rsp_rdata); end
  endtask

  task automatic test_round_robin();
    logic [1:0] g_seen, r_seen, exp_vec;
    reset = 1'b1; repeat (2) @(negedge clk); reset = 1'b0;
    req_rwb = 2'b00; req_addr = {7'h02, 7'h01}; req_wdata = {16'h2222, 16'h1111};
    req_valid = 2'b11;
    for (int f = 0; f < 4; f++) begin
      exp_vec = 2'(1 << (f % 2));
      g_seen = '0; r_seen = '0;
      for (int n = 0; n < 400; n++) begin
        @(negedge clk);
        if (req_ready != 2'b00) begin g_seen = req_ready; break; end
      end
      total++; if (g_seen !== exp_vec) begin bad++; $display("FAIL rr_grant%0d got=%b want=%b", f, g_seen, exp_vec); end
      for (int n = 0; n < 400; n++) begin
        @(negedge clk);
        if (rsp_valid != 2'b00) begin r_seen = rsp_valid; break; end
      end
      total++; if (r_seen !== exp_vec) begin bad++; $display("FAIL rr_rsp%0d got=%b want=%b", f, r_seen, exp_vec); end
    end
    req_valid = 2'b00;
    sb_mem[1] = 16'h1111; sb_mem[2] = 16'h2222;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset_midframe();
    bit ok; int cnt;
    req_rwb[0] = 1'b0; req_addr[6:0] = 7'h03; req_wdata[15:0] = 16'hDEAD; req_valid[0] = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (req_ready[0]) begin ok = 1'b1; break; end
    end
    req_valid[0] = 1'b0;
    total++; if (!ok) begin bad++; $display("FAIL mid_accept got=0 want=1"); end
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (sl_bits == 10) begin ok = 1'b1; break; end
    end
    total++; if (!ok) begin bad++; $display("FAIL mid_bit10 got=%0d want=10", sl_bits); end
    reset = 1'b1;
    @(negedge clk);
    total++; if (csz !== 1'b1)  begin bad++; $display("FAIL mid_csz got=%b want=1", csz); end
    total++; if (sclk !== 1'b0) begin bad++; $display("FAIL mid_sclk got=%b want=0", sclk); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b want=0", busy); end
    reset = 1'b0;
    cnt = 0;
    for (int n = 0; n < 120; n++) begin
      if (rsp_valid != 2'b00) cnt++;
      @(negedge clk);
    end
    total++; if (cnt !== 0) begin bad++; $display("FAIL mid_no_rsp got=%0d want=0", cnt); end
    req_rwb = 2'b11; req_addr = {7'h15, 7'h01}; req_valid = 2'b11;
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin ok = 1'b1; break; end
    end
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL mid_ptr_reset got=%b want=01", req_ready); end
    req_valid[0] = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (req_ready[1]) break;
    end
    req_valid[1] = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    total++; if (!ok) begin bad++; $display("FAIL mid_drain busy=%b want=0", busy); end
  endtask

  task automatic test_random();
    bit ok; int lat; logic [15:0] rd; int idx; bit rwb; logic [6:0] addr; logic [15:0] wd; int mm;
    for (int f = 0; f < 40; f++) begin
      idx  = int'($urandom_range(0, 1));
      rwb  = 1'($urandom_range(0, 1));
      addr = 7'($urandom_range(0, 7));
      wd   = 16'($urandom);
      issue(idx, rwb, addr, wd, ok, lat, rd);
      total++; if (!ok || lat !== FRAME_LAT) begin bad++; $display("FAIL rnd_lat%0d ok=%b got=%0d want=%0d", f, ok, lat, FRAME_LAT); end
      total++;
      if (rwb) begin
        if (rd !== sb_mem[addr]) begin bad++; $display("FAIL rnd_rdata%0d got=%h want=%h", f, rd, sb_mem[addr]); end
      end else begin
        if (rd !== 16'h0) begin bad++; $display("FAIL rnd_wr_rdata%0d got=%h want=0000", f, rd); end
        sb_mem[addr] = wd;
      end
    end
    repeat (10) @(negedge clk);
    mm = 0;
    for (int a = 0; a < 128; a++) if (sl_mem[a] !== sb_mem[a]) mm++;
    total++; if (mm !== 0)       begin bad++; $display("FAIL mem_compare got=%0d diffs want=0", mm); end
    total++; if (sdi_viol !== 0) begin bad++; $display("FAIL sdi_stable got=%0d changes want=0", sdi_viol); end
    total++; if (min_gap < GAP_CYC || min_gap >= 1000) begin bad++; $display("FAIL csz_gap got=%0d want>=%0d", min_gap, GAP_CYC); end
  endtask

  initial begin
    for (int a = 0; a < 128; a++) sb_mem[a] = '0;
    test_reset();
    test_write();
    test_read();
    test_round_robin();
    test_reset_midframe();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
